// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the general register file: W stage first, MDU results
// buffered in a small FIFO, with a per-register busy scoreboard for decode.
module grf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic [31:0]   wb_pc,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_addr,
  input  logic [31:0]   lu_data,
  input  logic [31:0]   lu_pc,
  input  logic          issue_en,
  input  logic [4:0]    issue_addr,
  output logic [31:0]   busy_mask,
  output logic          grf_we,
  output logic [4:0]    grf_addr,
  output logic [31:0]   grf_data,
  output logic [31:0]   grf_pc,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [4:0]    mem_addr_q [DEPTH];
  logic [4:0]    mem_addr_d [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_pc_d   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;

  logic w_claim, fifo_empty, full, accept, pop, bypass, push;
  logic [31:0] set_mask, clr_mask;

  assign w_claim    = wb_en && (wb_addr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  // Ready depends only on registered occupancy so the MDU never sees a loop.
  assign lu_ready   = !full && !clr;
  assign accept     = lu_valid && lu_ready;

  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign busy_mask  = busy_q;

  always_comb begin
    grf_we   = 1'b0;
    grf_addr = 5'd0;
    grf_data = 32'd0;
    grf_pc   = 32'd0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (w_claim) begin
      grf_we   = 1'b1;
      grf_addr = wb_addr;
      grf_data = wb_data;
      grf_pc   = wb_pc;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      grf_we   = (mem_addr_q[rd_ptr_q] != 5'd0);
      grf_addr = mem_addr_q[rd_ptr_q];
      grf_data = mem_data_q[rd_ptr_q];
      grf_pc   = mem_pc_q[rd_ptr_q];
    end else if (lu_valid) begin
      bypass   = 1'b1;
      grf_we   = (lu_addr != 5'd0);
      grf_addr = lu_addr;
      grf_data = lu_data;
      grf_pc   = lu_pc;
    end
    if (clr) grf_we = 1'b0;
  end

  assign push = accept && !bypass;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_pc_d   = mem_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = lu_addr;
      mem_data_d[wr_ptr_q] = lu_data;
      mem_pc_d[wr_ptr_q]   = lu_pc;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set after clear so a same-cycle reissue of the committing register stays busy.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_en && (issue_addr != 5'd0) && !clr) set_mask[issue_addr] = 1'b1;
    if ((pop || bypass) && grf_we) clr_mask[grf_addr] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
    mem_pc_q   <= mem_pc_d;
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: a queue-based reference model predicts
// each cycle's write and status; a monitor compares what the DUT presents.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          clr, wb_en, lu_valid, lu_ready, issue_en, grf_we, fifo_full;
  logic [4:0]    wb_addr, lu_addr, issue_addr, grf_addr;
  logic [31:0]   wb_data, wb_pc, lu_data, lu_pc, busy_mask, grf_data, grf_pc;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clr(clr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_pc(wb_pc), .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr),
    .lu_data(lu_data), .lu_pc(lu_pc), .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_mask(busy_mask), .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data),
    .grf_pc(grf_pc), .fifo_count(fifo_count), .fifo_full(fifo_full)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  typedef struct packed {
    logic          we;
    logic          idle;
    logic [CW-1:0] cnt;
    logic          full;
    logic          rdy;
    logic [31:0]   busy;
  } st_t;

  ent_t  m_fifo[$];
  logic  m_busy[32];
  ent_t  exp_wr[$];
  st_t   exp_st[$];
  bit    m_acc;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Drives one cycle of inputs and predicts that cycle's output and the next state.
  task automatic step(input logic c, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] wp,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [31:0] lp, input logic ie, input logic [4:0] ia);
    st_t  s;
    ent_t w, lu;
    bit   wr, byp, rdy, src_mdu;
    @(negedge clk);
    clr = c; wb_en = we; wb_addr = wa; wb_data = wd; wb_pc = wp;
    lu_valid = lv; lu_addr = la; lu_data = ld; lu_pc = lp;
    issue_en = ie; issue_addr = ia;
    wr = 0; byp = 0; src_mdu = 0;
    w = '0;
    lu = '{a: la, d: ld, p: lp};
    s.cnt  = CW'(m_fifo.size());
    s.full = (m_fifo.size() == DEPTH);
    s.busy = busy_vec();
    rdy    = !c && (m_fifo.size() < DEPTH);
    s.rdy  = rdy;
    m_acc  = lv && rdy;
    if (we && wa != 0) begin
      wr = 1; w = '{a: wa, d: wd, p: wp};
    end else if (m_fifo.size() > 0) begin
      w = m_fifo[0]; wr = (w.a != 0); src_mdu = 1;
      if (!c) void'(m_fifo.pop_front());
    end else if (lv) begin
      w = lu; wr = (la != 0); byp = 1; src_mdu = 1;
    end
    s.idle = !(we && wa != 0) && !src_mdu;
    if (c) wr = 0;
    s.we = wr;
    exp_st.push_back(s);
    if (wr) exp_wr.push_back(w);
    if (c) begin
      m_fifo.delete();
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (m_acc && !byp) m_fifo.push_back(lu);
      if (wr && src_mdu) m_busy[w.a] = 0;
      if (ie && ia != 0) m_busy[ia] = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    st_t  s;
    ent_t w;
    forever begin
      @(negedge clk);
      #3;
      if (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        chk("grf_we", 64'(grf_we), 64'(s.we));
        chk("fifo_count", 64'(fifo_count), 64'(s.cnt));
        chk("fifo_full", 64'(fifo_full), 64'(s.full));
        chk("lu_ready", 64'(lu_ready), 64'(s.rdy));
        chk("busy_mask", 64'(busy_mask), 64'(s.busy));
        if (s.idle && !clr)
          chk("idle_outputs", {27'd0, grf_addr, grf_data}, 64'd0);
      end
      if (grf_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(grf_addr), 64'hFFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("grf_addr", 64'(grf_addr), 64'(w.a));
          chk("grf_data", 64'(grf_data), 64'(w.d));
          chk("grf_pc", 64'(grf_pc), 64'(w.p));
        end
      end
    end
  end

  initial begin : driver
    logic        h_v;
    logic [4:0]  h_a;
    logic [31:0] h_d, h_p;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    clr = 1; wb_en = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; lu_pc = 0; issue_en = 0; issue_addr = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // bypass
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    step(0, 0, 0, 0, 0, 1, 8, 32'h1234_5678, 32'h100, 0, 0);
    idle(1);

    // contention, full hold, ordered drain
    step(0, 1, 3, 32'hA1, 32'h200, 1, 9,  32'h99, 32'h300, 1, 9);
    step(0, 1, 3, 32'hA2, 32'h204, 1, 10, 32'hAA, 32'h304, 1, 10);
    step(0, 1, 3, 32'hA3, 32'h208, 1, 11, 32'hBB, 32'h308, 0, 0);
    step(0, 1, 3, 32'hA4, 32'h20C, 1, 11, 32'hBB, 32'h308, 0, 0);
    step(0, 0, 0, 0, 0, 1, 11, 32'hBB, 32'h308, 0, 0);
    step(0, 0, 0, 0, 0, 1, 11, 32'hBB, 32'h308, 0, 0);
    idle(3);

    // scoreboard race and issue to $0
    step(0, 1, 3, 32'h1, 32'h400, 1, 5, 32'h55, 32'h500, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // zero register
    step(0, 1, 3, 32'h2, 32'h404, 1, 0, 32'h77, 32'h504, 0, 0);
    step(0, 1, 0, 32'h3, 32'h408, 0, 0, 0, 0, 0, 0);
    idle(1);

    // reset mid-operation
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 1, 4, 32'h4, 32'h40C, 1, 9, 32'h90, 32'h600, 1, 10);
    step(0, 1, 4, 32'h5, 32'h410, 1, 10, 32'hA0, 32'h604, 0, 0);
    step(1, 0, 0, 0, 0, 1, 12, 32'hC0, 32'h608, 0, 0);
    step(0, 0, 0, 0, 0, 1, 12, 32'hC0, 32'h608, 0, 0);
    idle(1);

    // randomized traffic; the MDU holds its result until accepted
    h_v = 0; h_a = 0; h_d = 0; h_p = 0;
    for (int n = 0; n < 3000; n++) begin
      logic c, we, ie;
      logic [4:0] wa, ia;
      c = ($urandom_range(0, 99) == 0);
      if (!h_v && $urandom_range(0, 2) != 0) begin
        h_v = 1;
        h_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        h_d = $urandom; h_p = $urandom;
      end
      we = ($urandom_range(0, 2) != 0);
      wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ie = ($urandom_range(0, 3) == 0);
      ia = 5'($urandom_range(0, 31));
      step(c, we, wa, $urandom, $urandom, h_v, h_a, h_d, h_p, ie, ia);
      if (m_acc) h_v = 0;
    end
    idle(6);
    @(negedge clk);
    #4;
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("status_outstanding", 64'(exp_st.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Controls the single write port of the general register file (GRF). Two requesters share it: the pipeline W stage and the long-latency unit (MDU) result path.
- W stage has absolute priority and is never stalled. MDU results wait in a small FIFO until a free write slot.
- Keeps a per-register busy scoreboard so decode can stall reads or writes of registers with a pending long-latency result.
- Outputs drive GRF Regw/rd/data/PC directly.

Parameters:
- DEPTH, 2, MDU result FIFO entries; legal values 2 or 4.
- CW, 3, width of fifo_count; must hold 0..DEPTH.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- wb_en  in  1  W-stage write request.
- wb_addr  in  5  W-stage destination register.
- wb_data  in  32  W-stage write data.
- wb_pc  in  32  W-stage instruction PC.
- lu_valid  in  1  MDU result valid.
- lu_ready  out  1  FIFO can accept an MDU result this cycle.
- lu_addr  in  5  MDU destination register.
- lu_data  in  32  MDU result data.
- lu_pc  in  32  MDU instruction PC.
- issue_en  in  1  decode issued a long-latency op this cycle.
- issue_addr  in  5  destination of the issued op.
- busy_mask  out  32  bit r=1 means a long-latency write to $r is pending.
- grf_we  out  1  to GRF Regw.
- grf_addr  out  5  to GRF rd.
- grf_data  out  32  to GRF data.
- grf_pc  out  32  to GRF PC.
- fifo_count  out  CW  occupied FIFO entries.
- fifo_full  out  1  fifo_count==DEPTH.

Behaviour:
- Definitions:
  - W claim = wb_en && wb_addr!=0.
  - Accept = lu_valid && lu_ready.
- lu_ready = !fifo_full && !clr. It is a function of registered count only, never of lu_valid.
- Write-port select, combinational, evaluated every cycle in this priority:
  1. W claim: grf_we=1 and grf_* = wb_*. Zero latency, so W-stage timing is unchanged.
  2. Otherwise, FIFO non-empty: grf_* = head entry. grf_we=1 only if head addr!=0. Head pops at posedge.
  3. Otherwise, FIFO empty and lu_valid: bypass. grf_* = lu_*, grf_we = (lu_addr!=0). The result is not pushed.
  4. Otherwise: grf_we=0, grf_addr=0, grf_data=0, grf_pc=0.
- Push: an accepted result that is not bypassed is written at the tail at posedge.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
- MDU results commit in acceptance order. W writes may commit ahead of older buffered MDU writes.
  - WAW safety is the responsibility of decode, which must stall on busy_mask.
  - The arbiter does not compare addresses.
- Entries with addr 0:
  - W claim with wb_addr 0 is treated as no claim.
  - An MDU entry with addr 0 still occupies a slot and consumes a drain cycle, but produces no write.
- Scoreboard, at posedge:
  - Set bit issue_addr when issue_en && issue_addr!=0.
  - Clear bit grf_addr when the selected source is FIFO head or bypass and grf_we=1.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
- Reset (clr=1 at posedge): FIFO pointers and count go to 0, busy_mask goes to 0.
  - While clr=1: grf_we forced 0, lu_ready forced 0, scoreboard sets ignored.
  - A reset mid-drain discards all buffered results. The GRF clears itself on the same clr.
- Output values after reset: grf_we=0, grf_addr=0, grf_data=0, grf_pc=0, fifo_count=0, fifo_full=0, busy_mask=0, lu_ready=1 once clr deasserts.
- Overflow cannot occur: lu_valid while lu_ready=0 is ignored, and the MDU must hold its result.

Test Plan:
- Bypass: FIFO empty, wb_en=0, lu_valid=1, lu_addr=8, lu_data=32'h1234_5678, busy bit 8 set -> same cycle grf_we=1, grf_addr=8, grf_data=32'h1234_5678; next cycle busy_mask[8]=0 and fifo_count=0.
- Contention: wb_en=1 with wb_addr=3 for 3 cycles while the MDU presents addr 9 then addr 10 -> grf shows $3 writes for 3 cycles. fifo_count goes 1 then 2, fifo_full=1, lu_ready=0. After wb_en drops, $9 drains, then $10, in order, and fifo_count returns to 0.
- Full hold: DEPTH=2 full, lu_valid=1 with addr 11 held, wb_en held 1 -> no accept and count stays 2. When wb_en=0: one pop per cycle, lu_ready=1 after the first pop, and the $11 result is accepted in that cycle.
- Scoreboard race: issue_en with addr 5 in the same cycle as a buffered write to $5 commits -> busy_mask[5]=1 afterwards. issue_addr=0 -> busy_mask unchanged.
- Zero register: wb_en=1 with wb_addr=0, FIFO head addr 0 -> grf_we=0, the head pops, and no busy bit changes.
- Reset mid-operation: fifo_count=2 and busy_mask=32'h0000_0600, assert clr for 1 cycle -> during clr grf_we=0 and lu_ready=0; after it fifo_count=0, busy_mask=0, and the next lu_valid is bypassed.
